// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing the MIPS32 unified single-port word memory between fetch, data and host ports.
// Optional grant/conflict statistics counters are built when ARB_STATS_EN is defined.
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_gnt_o,
    output logic          dm_rvalid_o,
    output logic [DW-1:0] dm_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    input  logic          cpu_halted_i,
    output logic          host_mode_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [31:0]   stat_if_gnt_o,
    output logic [31:0]   stat_dm_gnt_o,
    output logic [31:0]   stat_conflict_o
);

    typedef enum logic {RUN, HOST} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DM, SEL_HOST} rsel_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    rsel_t      rsel, rd_sel;
    logic [3:0] starve_cnt;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        if_gnt_o   = 1'b0;
        dm_gnt_o   = 1'b0;
        host_gnt_o = 1'b0;
        if (state == HOST) begin
            host_gnt_o = host_req_i & cpu_halted_i;
        end else if (if_req_i && (starve_cnt == STARVE_LIM || !dm_req_i)) begin
            if_gnt_o = 1'b1;
        end else if (dm_req_i) begin
            dm_gnt_o = 1'b1;
        end
    end

    // Memory command follows the single granted port; write data is zeroed on reads.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rd_sel      = SEL_NONE;
        if (host_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_we_i ? host_wdata_i : '0;
            rd_sel      = host_we_i ? SEL_NONE : SEL_HOST;
        end else if (dm_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = dm_we_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_we_i ? dm_wdata_i : '0;
            rd_sel      = dm_we_i ? SEL_NONE : SEL_DM;
        end else if (if_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = if_addr_i;
            rd_sel      = SEL_IF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            starve_cnt <= '0;
            rsel       <= SEL_NONE;
        end else begin
            rsel <= rd_sel;
            case (state)
                RUN: begin
                    if (if_req_i && !if_gnt_o)
                        starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
                    else
                        starve_cnt <= '0;
                    if (host_req_i && cpu_halted_i)
                        state <= HOST;
                end
                HOST: begin
                    if (!host_req_i || !cpu_halted_i)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign host_mode_o   = (state == HOST);
    assign if_rvalid_o   = (rsel == SEL_IF);
    assign dm_rvalid_o   = (rsel == SEL_DM);
    assign host_rvalid_o = (rsel == SEL_HOST);
    assign if_rdata_o    = if_rvalid_o   ? mem_rdata_i : '0;
    assign dm_rdata_o    = dm_rvalid_o   ? mem_rdata_i : '0;
    assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;

`ifdef ARB_STATS_EN
    logic [31:0] stat_if_q, stat_dm_q, stat_cf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_q <= '0;
            stat_dm_q <= '0;
            stat_cf_q <= '0;
        end else if (state == RUN) begin
            if (if_gnt_o && stat_if_q != '1)
                stat_if_q <= stat_if_q + 32'd1;
            if (dm_gnt_o && stat_dm_q != '1)
                stat_dm_q <= stat_dm_q + 32'd1;
            if (if_req_i && dm_req_i && stat_cf_q != '1)
                stat_cf_q <= stat_cf_q + 32'd1;
        end
    end

    assign stat_if_gnt_o   = stat_if_q;
    assign stat_dm_gnt_o   = stat_dm_q;
    assign stat_conflict_o = stat_cf_q;
`else
    assign stat_if_gnt_o   = '0;
    assign stat_dm_gnt_o   = '0;
    assign stat_conflict_o = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a vector table for the main sequences plus
// hand-written host-blocked and reset-mid-read cases, against a behavioural memory.
module tb_mips_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [AW-1:0] dm_addr_i = '0;
    logic [DW-1:0] dm_wdata_i = '0;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          host_req_i = 1'b0, host_we_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [DW-1:0] host_wdata_i = '0;
    logic          host_gnt_o, host_rvalid_o;
    logic [DW-1:0] host_rdata_o;
    logic          cpu_halted_i = 1'b0;
    logic          host_mode_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [31:0]   stat_if_gnt_o, stat_dm_gnt_o, stat_conflict_o;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .cpu_halted_i(cpu_halted_i), .host_mode_o(host_mode_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .stat_if_gnt_o(stat_if_gnt_o), .stat_dm_gnt_o(stat_dm_gnt_o),
        .stat_conflict_o(stat_conflict_o)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= mem[mem_addr_o];
        end
    end

    typedef struct {
        logic          ifr;  logic [AW-1:0] ifa;
        logic          dmr;  logic dmwe; logic [AW-1:0] dma; logic [DW-1:0] dmwd;
        logic          hr;   logic hwe;  logic [AW-1:0] ha;  logic [DW-1:0] hwd;
        logic          halt;
        logic [3:0]    e_gnt;          // {if, dm, host, host_mode}
        logic          e_en; logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_wd;
        logic [2:0]    e_rv;           // {if, dm, host}
        logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic ifr, input int ifa,
        input logic dmr, input logic dmwe, input int dma, input logic [DW-1:0] dmwd,
        input logic hr, input logic hwe, input int ha, input logic [DW-1:0] hwd,
        input logic halt,
        input logic [3:0] e_gnt, input logic e_en, input logic e_we, input int e_addr,
        input logic [DW-1:0] e_wd, input logic [2:0] e_rv, input logic [DW-1:0] e_rd);
        vec_t v;
        v.ifr = ifr; v.ifa = AW'(ifa);
        v.dmr = dmr; v.dmwe = dmwe; v.dma = AW'(dma); v.dmwd = dmwd;
        v.hr = hr; v.hwe = hwe; v.ha = AW'(ha); v.hwd = hwd;
        v.halt = halt;
        v.e_gnt = e_gnt; v.e_en = e_en; v.e_we = e_we; v.e_addr = AW'(e_addr); v.e_wd = e_wd;
        v.e_rv = e_rv; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_req_i = v.ifr;   if_addr_i = v.ifa;
        dm_req_i = v.dmr;   dm_we_i = v.dmwe; dm_addr_i = v.dma; dm_wdata_i = v.dmwd;
        host_req_i = v.hr;  host_we_i = v.hwe; host_addr_i = v.ha; host_wdata_i = v.hwd;
        cpu_halted_i = v.halt;
    endtask

    task automatic idle();
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; host_req_i = 1'b0; host_we_i = 1'b0;
        cpu_halted_i = 1'b0;
    endtask

    // Drive both CPU ports: fetch of addr 1, data load of addr 5.
    task automatic contend();
        idle();
        if_req_i = 1'b1; if_addr_i = AW'(1);
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = AW'(5);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [$];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[5] = 32'h55;

        //            ifr ifa dmr we  dma dmwd        hr hwe ha hwd         hlt gnt      en we ad wd          rv      rd
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b0000, 0, 0, 0, 0,          3'b000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b1000, 1, 0, 0, 0,          3'b000, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b1000, 1, 0, 1, 0,          3'b100, 32'hA));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b1000, 1, 0, 2, 0,          3'b100, 32'hB));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b0000, 0, 0, 0, 0,          3'b100, 32'hC));
        vecs.push_back(mk(0, 0, 1, 1, 9, 32'h1234,    0, 0, 0, 0,           0, 4'b0100, 1, 1, 9, 32'h1234,   3'b000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 9, 32'hFFFF,    0, 0, 0, 0,           0, 4'b0100, 1, 0, 9, 0,          3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b0000, 0, 0, 0, 0,          3'b010, 32'h1234));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b0100, 1, 0, 5, 0,          3'b000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b0100, 1, 0, 5, 0,          3'b010, 32'h55));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b0100, 1, 0, 5, 0,          3'b010, 32'h55));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b0100, 1, 0, 5, 0,          3'b010, 32'h55));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b1000, 1, 0, 1, 0,          3'b010, 32'h55));
        vecs.push_back(mk(1, 1, 1, 0, 5, 0,           0, 0, 0, 0,           0, 4'b0100, 1, 0, 5, 0,          3'b100, 32'hB));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b0000, 0, 0, 0, 0,          3'b010, 32'h55));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,           1, 1, 3, 32'hDEAD,    1, 4'b1000, 1, 0, 0, 0,          3'b000, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,           1, 1, 3, 32'hDEAD,    1, 4'b0011, 1, 1, 3, 32'hDEAD,   3'b100, 32'hA));
        vecs.push_back(mk(1, 0, 1, 0, 5, 0,           1, 0, 3, 32'h77,      1, 4'b0011, 1, 0, 3, 0,          3'b000, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0,           0, 0, 0, 0,           1, 4'b0001, 0, 0, 0, 0,          3'b001, 32'hDEAD));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0,           0, 0, 0, 0,           1, 4'b1000, 1, 0, 2, 0,          3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0,           0, 4'b0000, 0, 0, 0, 0,          3'b100, 32'hC));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d gnt", i), 64'({if_gnt_o, dm_gnt_o, host_gnt_o, host_mode_o}),
                  64'(vecs[i].e_gnt));
            check($sformatf("v%0d memcmd", i), 64'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                  64'({vecs[i].e_en, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wd}));
            check($sformatf("v%0d rvalid", i), 64'({if_rvalid_o, dm_rvalid_o, host_rvalid_o}),
                  64'(vecs[i].e_rv));
            check($sformatf("v%0d if_rdata", i), 64'(if_rdata_o),
                  64'(vecs[i].e_rv[2] ? vecs[i].e_rd : '0));
            check($sformatf("v%0d dm_rdata", i), 64'(dm_rdata_o),
                  64'(vecs[i].e_rv[1] ? vecs[i].e_rd : '0));
            check($sformatf("v%0d host_rdata", i), 64'(host_rdata_o),
                  64'(vecs[i].e_rv[0] ? vecs[i].e_rd : '0));
            next_cycle();
        end

        // Host request while the core runs is never honoured.
        idle();
        host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = AW'(7); host_wdata_i = 32'hBAD;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("host_blocked c%0d", c), 64'({host_gnt_o, host_mode_o, mem_en_o}), 64'(0));
            next_cycle();
        end

        // Reset in the cycle after a fetch grant drops the pending response.
        idle();
        if_req_i = 1'b1; if_addr_i = AW'(0);
        @(negedge clk);
        check("rst_if gnt", 64'(if_gnt_o), 64'(1));
        next_cycle();
        idle();
        check("rst_if pending", 64'(if_rvalid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_if drop", 64'(if_rvalid_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_if after", 64'({if_rvalid_o, dm_rvalid_o, host_rvalid_o, host_mode_o}), 64'(0));
        next_cycle();

        // Reset with starve_cnt part-way up: counter must restart from zero.
        contend();
        repeat (3) next_cycle();
        idle();
        check("rst_dm pending", 64'(dm_rvalid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_dm drop", 64'(dm_rvalid_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        contend();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("starve_after_rst c%0d", c), 64'({if_gnt_o, dm_gnt_o}),
                  64'((c == 4) ? 2'b10 : 2'b01));
            next_cycle();
        end
        idle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Single-cycle arbiter that shares the pipelined MIPS32 core's unified single-port word memory between three requesters: the instruction fetch (IF) port, the data (MEM-stage LW/SW) port and a host loader/debug port.
- Decides the owner of the memory every clock, drives the memory command and routes the one-cycle-latency read data back to the requester that issued the read.
- Includes a starvation guard so fetch cannot be locked out by back-to-back data traffic.
- The host may only take the memory while the core is halted.

Parameters:
- AW, 10, word-address width (1024 words)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets priority over data (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  AW  fetch word address
- if_gnt_o  out  1  fetch granted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DW  fetch read data
- dm_req_i  in  1  data request
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  AW  data word address
- dm_wdata_i  in  DW  store data
- dm_gnt_o  out  1  data granted
- dm_rvalid_o  out  1  load data valid
- dm_rdata_o  out  DW  load data
- host_req_i  in  1  host request
- host_we_i  in  1  host write enable
- host_addr_i  in  AW  host address
- host_wdata_i  in  DW  host write data
- host_gnt_o  out  1  host granted
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  DW  host read data
- cpu_halted_i  in  1  core HALTED flag
- host_mode_o  out  1  arbiter in HOST state
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = RUN, starve_cnt = 0, all *_rvalid_o = 0, host_mode_o = 0. Grants, mem_en_o and mem_we_o are combinational and therefore 0 whenever there is no request.
- Reset mid-operation: a pending rvalid is dropped, with no response after reset.
- States:
  - RUN: CPU ports arbitrated; host_gnt_o = 0.
  - HOST: only host granted; if_gnt_o = dm_gnt_o = 0.
- Transitions (registered):
  - RUN -> HOST when host_req_i = 1 and cpu_halted_i = 1 at the clock edge.
  - HOST -> RUN when host_req_i = 0 or cpu_halted_i = 0.
  - The first host grant therefore occurs the cycle after entry.
- RUN priority:
  - Default: dm over if.
  - If starve_cnt == STARVE_MAX: if over dm.
  - At most one grant per cycle; req and gnt are in the same cycle.
  - A requester that is not granted holds its request and address.
- starve_cnt:
  - +1 when if_req_i = 1 and if_gnt_o = 0 in RUN; saturates at STARVE_MAX.
  - Cleared on if_gnt_o or when if_req_i = 0.
  - Holds in HOST.
- Memory command:
  - Driven from the granted port; mem_en_o = any grant.
  - mem_we_o = granted port's we (always 0 for fetch).
  - mem_wdata_o = 0 when the command is not a write.
- Read return:
  - A granted read registers rsel (requester id); the matching rvalid is 1 exactly one cycle later.
  - rdata_o = mem_rdata_i when its rvalid = 1, else 0.
  - Writes produce no rvalid.
  - Back-to-back reads produce back-to-back rvalids.
- Ownership change: a read granted in the last RUN cycle still returns its rvalid in the first HOST cycle, and vice versa. Responses are never dropped except on reset.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs stat_if_gnt_o, stat_dm_gnt_o and stat_conflict_o, each 32 bits.
  - Saturating counters of fetch grants, data grants, and RUN cycles with both if_req_i and dm_req_i high.
  - Reset 0; counters hold in HOST.
- Undefined: counters are not built; the ports exist and are tied to 0.

Test Plan:
- Fetch only: if_req_i=1 for addr 0,1,2, memory preloaded 0xA,0xB,0xC -> if_gnt_o=1 each cycle; if_rvalid_o one cycle later with 0xA, 0xB, 0xC in order.
- Contention: if_req_i and dm_req_i both held high, dm load of addr 5 -> dm_gnt_o=1 for 4 cycles; if_gnt_o=1 on cycle 5 (starve_cnt reached 4); dm regains priority on cycle 6.
- Store then load: dm store 0x1234 to addr 9, then dm load addr 9 -> mem_we_o=1 on the store cycle; dm_rdata_o=0x1234 with dm_rvalid_o one cycle after the load grant.
- Host blocked: host_req_i=1 with cpu_halted_i=0 -> host_gnt_o stays 0 and host_mode_o stays 0 for 10 cycles.
- Host load: cpu_halted_i=1, host writes 0xDEAD to addr 3 then reads addr 3 -> host_mode_o=1 the next cycle; CPU grants = 0; host_rdata_o=0xDEAD; dropping host_req_i returns to RUN the next cycle.
- Reset mid-read: rst_n pulsed low in the cycle after an if grant -> if_rvalid_o=0 immediately and stays 0 after release; starve_cnt=0.
